// File: rtl/count_sched_pkg.sv
// count_scheduler shared types: FSM state encoding and default sizes.
// Imported by the scheduler top and its counter datapath.
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/count_scheduler_counter.sv
// sched_counter: shared WIDTH-bit up-counter with synchronous clear and enable.
// Clear wins over enable; with neither asserted the value holds.
module sched_counter
  import count_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/count_scheduler.sv
// count_scheduler: round-robin owner of one shared up-counter.
// Grants, clears, runs to the owner's latched terminal count, pulses done.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] tc,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] tc_q, tc_d;

  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    scan_idx;
  logic             win_ok;
  logic             own_req;
  logic             cnt_clr;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt;
  int               j;

  // Scan upward from last+1 so the previous owner is checked last.
  always_comb begin
    win_ok   = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    j        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j        = (int'(last_q) + k) % NREQ;
      scan_idx = IW'(j);
      if (!win_ok && req[scan_idx]) begin
        win_ok  = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign own_req = req[owner_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    last_d  = last_q;
    owner_d = owner_q;
    tc_d    = tc_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_ok) begin
          state_d          = LOAD;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          owner_d          = win_idx;
          tc_d             = tc[int'(win_idx)*WIDTH +: WIDTH];
        end
      end
      LOAD: begin
        if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          last_d  = owner_q;
        end else begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          last_d  = owner_q;
        end else if (cnt == tc_q) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      tc_q    <= tc_d;
    end
  end

  sched_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clock(clock),
    .clr  (cnt_clr | ~clear_n),
    .en   (cnt_en),
    .count(cnt)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = cnt;

endmodule
